// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR write-back path: line address type,
// line geometry, default FIFO depth and the packer state encoding.
package fir_pkg;

    typedef logic [41:0] t_hc_address;

    localparam int FIR_LINE_BYTES = 64;
    localparam int FIR_LINE_BITS  = FIR_LINE_BYTES * 8;
    localparam int WB_FIFO_DEPTH  = 4;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RUN   = 2'd1,
        WB_DRAIN = 2'd2,
        WB_DONE  = 2'd3
    } t_wb_state;

    // Destination line address of the idx-th issued line; wraps modulo 2^42.
    function automatic t_hc_address line_addr(input t_hc_address base, input logic [31:0] idx);
        return base + t_hc_address'(idx);
    endfunction

endpackage

// File: rtl/fir_wb_fifo.sv
// Circular line buffer between the byte packer and the write channel.
// Head is read combinationally so the issuing register captures it on the pop edge.
module fir_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;
    assign head    = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fir_wb_packer.sv
// Packs FIR output bytes into 64-byte lines and issues them as single-line
// CCI-P writes, counting responses to decide when the job has fully landed.
module fir_wb_packer
    import fir_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  t_hc_address              base_addr,
    input  logic [31:0]              num_lines,
    input  logic [7:0]               data_in,
    input  logic                     valid_in,
    input  logic                     c1_almfull,
    input  logic                     c1_rsp_valid,
    output logic                     c1_tx_valid,
    output t_hc_address              c1_tx_addr,
    output logic [FIR_LINE_BITS-1:0] c1_tx_data,
    output logic [15:0]              c1_tx_mdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam int BYTE_W = $clog2(FIR_LINE_BYTES);

    t_wb_state                state_q, state_d;
    t_hc_address              base_q, base_d;
    logic [31:0]              num_lines_q, num_lines_d;
    logic [BYTE_W-1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]              lines_rx_q, lines_rx_d;
    logic [31:0]              issued_q, issued_d;
    logic [31:0]              resp_q, resp_d;
    logic [FIR_LINE_BITS-1:0] line_q, line_d;
    logic                     error_q, error_d;
    logic                     tx_valid_q, tx_valid_d;
    t_hc_address              tx_addr_q, tx_addr_d;
    logic [FIR_LINE_BITS-1:0] tx_data_q, tx_data_d;
    logic [15:0]              tx_mdata_q, tx_mdata_d;

    logic                     in_run;
    logic                     active;
    logic                     start_ok;
    logic                     accept;
    logic                     line_done;
    logic                     last_line;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     drop;
    logic [FIR_LINE_BITS-1:0] line_ins;
    logic [FIR_LINE_BITS-1:0] fifo_head;

    assign in_run    = (state_q == WB_RUN);
    assign active    = (state_q == WB_RUN) || (state_q == WB_DRAIN);
    assign start_ok  = start && ((state_q == WB_IDLE) || (state_q == WB_DONE));
    assign accept    = valid_in && in_run;
    assign line_done = accept && (byte_idx_q == BYTE_W'(FIR_LINE_BYTES - 1));
    assign last_line = line_done && ((lines_rx_q + 32'd1) == num_lines_q);
    assign fifo_push = line_done && !fifo_full;
    assign drop      = line_done && fifo_full;
    assign fifo_pop  = active && !fifo_empty && !c1_almfull;

    // The incoming byte is merged into its lane so the 64th byte lands in the pushed line.
    for (genvar gi = 0; gi < FIR_LINE_BYTES; gi++) begin : g_lane
        assign line_ins[gi*8 +: 8] = (byte_idx_q == BYTE_W'(gi)) ? data_in : line_q[gi*8 +: 8];
    end

    fir_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIR_LINE_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (start_ok),
        .push      (fifo_push),
        .push_data (line_ins),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= WB_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WB_IDLE, WB_DONE: begin
                if (start) state_d = (num_lines == 32'd0) ? WB_DONE : WB_RUN;
            end
            WB_RUN: begin
                if (last_line) state_d = WB_DRAIN;
            end
            WB_DRAIN: begin
                if (fifo_empty && (resp_q == issued_q)) state_d = WB_DONE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == WB_RUN) || (state_q == WB_DRAIN);
        done = (state_q == WB_DONE);
    end

    always_comb begin
        base_d      = base_q;
        num_lines_d = num_lines_q;
        byte_idx_d  = byte_idx_q;
        lines_rx_d  = lines_rx_q;
        issued_d    = issued_q;
        resp_d      = resp_q;
        line_d      = line_q;
        error_d     = error_q;
        tx_valid_d  = 1'b0;
        tx_addr_d   = tx_addr_q;
        tx_data_d   = tx_data_q;
        tx_mdata_d  = tx_mdata_q;
        if (start_ok) begin
            base_d      = base_addr;
            num_lines_d = num_lines;
            byte_idx_d  = '0;
            lines_rx_d  = '0;
            issued_d    = '0;
            resp_d      = '0;
            line_d      = '0;
            error_d     = 1'b0;
        end else begin
            if (accept) begin
                byte_idx_d = byte_idx_q + 1'b1;
                line_d     = line_ins;
                if (line_done) lines_rx_d = lines_rx_q + 32'd1;
                if (drop)      error_d    = 1'b1;
            end
            // IDLE is only ever reached through reset, where stray bytes are harmless.
            if (valid_in && !in_run && (state_q != WB_IDLE)) error_d = 1'b1;
            if (fifo_pop) begin
                tx_valid_d = 1'b1;
                tx_addr_d  = line_addr(base_q, issued_q);
                tx_data_d  = fifo_head;
                tx_mdata_d = issued_q[15:0];
                issued_d   = issued_q + 32'd1;
            end
            if (active && c1_rsp_valid) resp_d = resp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q      <= '0;
            num_lines_q <= '0;
            byte_idx_q  <= '0;
            lines_rx_q  <= '0;
            issued_q    <= '0;
            resp_q      <= '0;
            line_q      <= '0;
            error_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_addr_q   <= '0;
            tx_data_q   <= '0;
            tx_mdata_q  <= '0;
        end else begin
            base_q      <= base_d;
            num_lines_q <= num_lines_d;
            byte_idx_q  <= byte_idx_d;
            lines_rx_q  <= lines_rx_d;
            issued_q    <= issued_d;
            resp_q      <= resp_d;
            line_q      <= line_d;
            error_q     <= error_d;
            tx_valid_q  <= tx_valid_d;
            tx_addr_q   <= tx_addr_d;
            tx_data_q   <= tx_data_d;
            tx_mdata_q  <= tx_mdata_d;
        end
    end

    assign c1_tx_valid = tx_valid_q;
    assign c1_tx_addr  = tx_addr_q;
    assign c1_tx_data  = tx_data_q;
    assign c1_tx_mdata = tx_mdata_q;
    assign error       = error_q;

endmodule

// File: tb/tb_fir_wb_packer.sv
// Bench for fir_wb_packer: a line-level reference model predicts each write
// request into a queue; a negedge monitor checks every request the DUT emits.
module tb_fir_wb_packer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [41:0]  base_addr = '0;
    logic [31:0]  num_lines = '0;
    logic [7:0]   data_in = '0;
    logic         valid_in = 1'b0;
    logic         c1_almfull = 1'b0;
    logic         c1_rsp_valid = 1'b0;
    logic         c1_tx_valid;
    logic [41:0]  c1_tx_addr;
    logic [511:0] c1_tx_data;
    logic [15:0]  c1_tx_mdata;
    logic         busy;
    logic         done;
    logic         error;

    always #5 clk = ~clk;

    fir_wb_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_lines    (num_lines),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .c1_almfull   (c1_almfull),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_tx_valid  (c1_tx_valid),
        .c1_tx_addr   (c1_tx_addr),
        .c1_tx_data   (c1_tx_data),
        .c1_tx_mdata  (c1_tx_mdata),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    typedef struct {
        logic [41:0]  addr;
        logic [15:0]  mdata;
        logic [511:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   req_seen = 0;
    logic af_edge = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // almfull as seen by the DUT at the most recent edge (the would-be pop edge).
    always @(posedge clk) af_edge <= c1_almfull;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && c1_tx_valid) begin
            req_seen++;
            $display("req addr=0x%011h mdata=0x%04h", c1_tx_addr, c1_tx_mdata);
            checks++;
            if (af_edge) begin
                errors++;
                $display("FAIL issue_under_almfull: got request at 0x%0h, expected none", c1_tx_addr);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_request: got addr 0x%0h, expected no request", c1_tx_addr);
            end else begin
                e = exp_q.pop_front();
                chk("req_addr", 64'(c1_tx_addr), 64'(e.addr));
                chk("req_mdata", 64'(c1_tx_mdata), 64'(e.mdata));
                checks++;
                if (c1_tx_data !== e.data) begin
                    errors++;
                    $display("FAIL req_data: got 0x%0h, expected 0x%0h", c1_tx_data, e.data);
                end
            end
        end
    end

    // mode 0: random almfull plus an ignored mid-run start; 1: almfull high for
    // the first `hold` cycles; 2: almfull high while bytes are still arriving.
    task automatic run_job(input logic [41:0] base, input int n, input int mode, input int hold,
                           input bit seq_data, input int abort_at, output int reqs_o);
        int           occ = 0;
        int           kept = 0;
        int           sent = 0;
        int           cyc = 0;
        int           rsp_sent = 0;
        int           req0;
        int           total;
        logic [511:0] line = '0;
        logic         af, v, r, pop, push, exp_err;
        logic [7:0]   d;
        exp_t         e;
        exp_err = 1'b0;
        total   = n * 64;
        req0    = req_seen;
        @(posedge clk); #1;
        base_addr = base; num_lines = 32'(n); start = 1'b1; valid_in = 1'b0; c1_rsp_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 3000) begin
            if (abort_at != 0 && sent == abort_at) break;
            if (sent == total && done) break;
            start = 1'b0;
            v = (sent < total) && ($urandom_range(0, 3) != 0);
            case (mode)
                0:       af = ($urandom_range(0, 3) == 0);
                1:       af = (cyc < hold);
                default: af = (sent < total);
            endcase
            r = ((req_seen - req0) > rsp_sent) && ($urandom_range(0, 1) == 1);
            d = seq_data ? 8'(sent) : 8'($urandom);
            if (mode == 0 && cyc == 7 && n > 0) begin
                start = 1'b1; base_addr = {10'($urandom), $urandom}; num_lines = $urandom;
            end
            valid_in = v; data_in = d; c1_almfull = af; c1_rsp_valid = r;
            // Reference: lines complete every 64 bytes, dropped if the buffer is full.
            pop  = (occ > 0) && !af;
            push = 1'b0;
            if (v) begin
                line[8*(sent%64) +: 8] = d;
                sent++;
                if (sent % 64 == 0) begin
                    if (occ == DEPTH) exp_err = 1'b1;
                    else begin
                        e.addr = base + 42'(kept); e.mdata = 16'(kept); e.data = line;
                        exp_q.push_back(e);
                        kept++;
                        push = 1'b1;
                    end
                end
            end
            occ = occ + int'(push) - int'(pop);
            if (r) rsp_sent++;
            cyc++;
            @(posedge clk); #1;
        end
        start = 1'b0; valid_in = 1'b0; c1_almfull = 1'b0; c1_rsp_valid = 1'b0;
        if (abort_at == 0) begin
            chk("job_done", 64'(done), 64'd1);
            chk("job_busy", 64'(busy), 64'd0);
            chk("job_error", 64'(error), 64'(exp_err));
            chk("job_req_count", 64'(req_seen - req0), 64'(kept));
            chk("job_missing_requests", 64'(exp_q.size()), 64'd0);
            $display("job base=0x%011h lines=%0d requests=%0d error=%0b", base, n, req_seen - req0, error);
        end
        reqs_o = req_seen - req0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_tx_valid"}, 64'(c1_tx_valid), 64'd0);
        chk({tag, "_tx_addr"}, 64'(c1_tx_addr), 64'd0);
        chk({tag, "_tx_data"}, 64'(|c1_tx_data), 64'd0);
        chk({tag, "_tx_mdata"}, 64'(c1_tx_mdata), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        int reqs;
        int req0;
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Zero-length job: done the cycle after start, never a request.
        req0 = req_seen;
        @(posedge clk); #1;
        base_addr = 42'h100; num_lines = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1 chk("zero_requests", 64'(req_seen - req0), 64'd0);

        run_job(42'h100, 1, 1, 0, 1'b1, 0, reqs);
        chk("single_requests", 64'(reqs), 64'd1);

        run_job(42'h100, 8, 1, 40, 1'b0, 0, reqs);
        chk("bp_requests", 64'(reqs), 64'd8);
        chk("bp_error", 64'(error), 64'd0);

        run_job(42'h100, 6, 2, 0, 1'b0, 0, reqs);
        chk("ovf_requests", 64'(reqs), 64'd4);
        chk("ovf_error", 64'(error), 64'd1);

        run_job(42'h3FF_FFFF_FFFF, 2, 1, 0, 1'b0, 0, reqs);
        chk("wrap_requests", 64'(reqs), 64'd2);

        // A byte arriving in DONE is discarded and flagged.
        @(posedge clk); #1 valid_in = 1'b1;
        @(posedge clk); #1 valid_in = 1'b0;
        chk("done_byte_error", 64'(error), 64'd1);
        chk("done_byte_done", 64'(done), 64'd1);

        for (int j = 0; j < 4; j++) begin
            run_job({10'($urandom), $urandom}, int'($urandom_range(1, 4)), 0, 0, 1'b0, 0, reqs);
        end

        // Reset mid-job after two of four lines.
        run_job(42'h300, 4, 1, 0, 1'b0, 128, reqs);
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        req0 = req_seen;
        for (int j = 0; j < 20; j++) begin
            valid_in = ($urandom_range(0, 1) == 1); data_in = 8'($urandom);
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        chk("postreset_requests", 64'(req_seen - req0), 64'd0);
        chk("postreset_idle_byte_error", 64'(error), 64'd0);
        chk("postreset_busy", 64'(busy), 64'd0);
        chk("postreset_done", 64'(done), 64'd0);

        run_job(42'h200, 1, 0, 0, 1'b0, 0, reqs);
        chk("after_reset_requests", 64'(reqs), 64'd1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
